ycbcr2rgb: RTL

- Converts a YCbCr 4:4:4 pixel stream back to RGB888 using fixed-point BT.601 full-range coefficients scaled by 256.
- Inverse of the RGB888→YCbCr stage. Sits after YCbCr-domain processing (filtering, thresholding) for display or debug.
- Four-stage pipeline. Frame sync signals are delayed to match the data path.

---
 rtl/ycbcr2rgb_pkg.sv | 27 ++
 rtl/ycbcr2rgb_if.sv | 32 +++
 rtl/ycbcr2rgb_sat_u8.sv | 19 +
 rtl/ycbcr2rgb.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ycbcr2rgb_pkg.sv
// Shared constants and types for the YCbCr -> RGB888 conversion block.
// Coefficients are BT.601 full-range values scaled by 2^FRAC_BITS.
package ycbcr2rgb_pkg;

  localparam int PIX_W     = 8;
  localparam int FRAC_BITS = 8;
  localparam int PIPE_LAT  = 4;
  localparam int PROD_W    = 20;
  localparam int CHROMA_OFS = 128;

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [PIX_W:0]    chroma_t;

  localparam prod_t   C_RV     = 20'sd359;
  localparam prod_t   C_GU     = 20'sd88;
  localparam prod_t   C_GV     = 20'sd183;
  localparam prod_t   C_BU     = 20'sd454;
  localparam chroma_t CHROMA_S = chroma_t'(CHROMA_OFS);

  // Frame sync bits that travel alongside each pixel.
  typedef struct packed {
    logic vsync;
    logic hsync;
    logic de;
  } sync_t;

endpackage

// File: rtl/ycbcr2rgb_if.sv
// Pixel stream bundle for the YCbCr -> RGB888 stage.
// The stream has no valid/ready handshake: a pixel is presented and taken
// on every clock, de only marks which pixels are active video, and the
// sink can never apply backpressure.
interface ycbcr2rgb_if;
  logic       pre_frame_vsync;
  logic       pre_frame_hsync;
  logic       pre_frame_de;
  logic [7:0] img_y;
  logic [7:0] img_cb;
  logic [7:0] img_cr;
  logic       post_frame_vsync;
  logic       post_frame_hsync;
  logic       post_frame_de;
  logic [7:0] rgb888_r;
  logic [7:0] rgb888_g;
  logic [7:0] rgb888_b;

  modport master (
    output pre_frame_vsync, pre_frame_hsync, pre_frame_de,
    output img_y, img_cb, img_cr,
    input  post_frame_vsync, post_frame_hsync, post_frame_de,
    input  rgb888_r, rgb888_g, rgb888_b
  );

  modport slave (
    input  pre_frame_vsync, pre_frame_hsync, pre_frame_de,
    input  img_y, img_cb, img_cr,
    output post_frame_vsync, post_frame_hsync, post_frame_de,
    output rgb888_r, rgb888_g, rgb888_b
  );
endinterface

// File: rtl/ycbcr2rgb_sat_u8.sv
// Clamp a signed 20-bit value into the unsigned 8-bit range 0..255.
module sat_u8 (
  input  logic signed [19:0] din_i,
  output logic        [7:0]  dout_o
);

  // Negative -> 0, anything above 255 -> 255, otherwise pass the low byte.
  always_comb begin
    dout_o = '0;
    if (din_i[19]) begin
      dout_o = 8'h00;
    end else if (|din_i[18:8]) begin
      dout_o = 8'hFF;
    end else begin
      dout_o = din_i[7:0];
    end
  end

endmodule

// File: rtl/ycbcr2rgb.sv
// YCbCr 4:4:4 -> RGB888, four-stage pipeline, one pixel per clock.
// Optional macro YCBCR2RGB_ROUND_EN: add half an LSB before the final
// shift (round-half-up) instead of a plain floor.
module ycbcr2rgb
  import ycbcr2rgb_pkg::*;
#(
  parameter bit BLANK_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  ycbcr2rgb_if.slave bus
);

`ifdef YCBCR2RGB_ROUND_EN
  localparam prod_t RND = 20'sd128;
`else
  localparam prod_t RND = 20'sd0;
`endif

  // S1: luma and offset-removed chroma
  logic [PIX_W-1:0] y_q,  y_d;
  chroma_t          db_q, db_d;
  chroma_t          dr_q, dr_d;

  // S2: products
  prod_t py_q,  py_d;
  prod_t prv_q, prv_d;
  prod_t pgu_q, pgu_d;
  prod_t pgv_q, pgv_d;
  prod_t pbu_q, pbu_d;

  // S3: channel sums
  prod_t r_sum_q, r_sum_d;
  prod_t g_sum_q, g_sum_d;
  prod_t b_sum_q, b_sum_d;

  // S4: clamped channels
  logic [PIX_W-1:0] r_q, r_d;
  logic [PIX_W-1:0] g_q, g_d;
  logic [PIX_W-1:0] b_q, b_d;

  prod_t r_shf, g_shf, b_shf;

  sync_t                 sync_in;
  sync_t [PIPE_LAT-1:0]  sync_q, sync_d;

  // Datapath next-state for every stage; data is taken every cycle.
  always_comb begin
    y_d     = bus.img_y;
    db_d    = $signed({1'b0, bus.img_cb}) - CHROMA_S;
    dr_d    = $signed({1'b0, bus.img_cr}) - CHROMA_S;

    py_d    = $signed({4'b0000, y_q, {FRAC_BITS{1'b0}}});
    prv_d   = C_RV * prod_t'(dr_q);
    pgu_d   = C_GU * prod_t'(db_q);
    pgv_d   = C_GV * prod_t'(dr_q);
    pbu_d   = C_BU * prod_t'(db_q);

    // Worst case magnitude is about 123k, well inside 20 signed bits.
    r_sum_d = py_q + prv_q;
    g_sum_d = py_q - pgu_q - pgv_q;
    b_sum_d = py_q + pbu_q;

    r_shf   = (r_sum_q + RND) >>> FRAC_BITS;
    g_shf   = (g_sum_q + RND) >>> FRAC_BITS;
    b_shf   = (b_sum_q + RND) >>> FRAC_BITS;

    sync_in = '{vsync: bus.pre_frame_vsync,
                hsync: bus.pre_frame_hsync,
                de:    bus.pre_frame_de};
    sync_d  = {sync_q[PIPE_LAT-2:0], sync_in};
  end

  sat_u8 u_sat_r (.din_i(r_shf), .dout_o(r_d));
  sat_u8 u_sat_g (.din_i(g_shf), .dout_o(g_d));
  sat_u8 u_sat_b (.din_i(b_shf), .dout_o(b_d));

  // Pipeline and sync delay registers, all cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      db_q    <= '0;
      dr_q    <= '0;
      py_q    <= '0;
      prv_q   <= '0;
      pgu_q   <= '0;
      pgv_q   <= '0;
      pbu_q   <= '0;
      r_sum_q <= '0;
      g_sum_q <= '0;
      b_sum_q <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      sync_q  <= '0;
    end else begin
      y_q     <= y_d;
      db_q    <= db_d;
      dr_q    <= dr_d;
      py_q    <= py_d;
      prv_q   <= prv_d;
      pgu_q   <= pgu_d;
      pgv_q   <= pgv_d;
      pbu_q   <= pbu_d;
      r_sum_q <= r_sum_d;
      g_sum_q <= g_sum_d;
      b_sum_q <= b_sum_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      sync_q  <= sync_d;
    end
  end

  logic blank;

  // Blanking gates the registered colour with the delayed de.
  always_comb begin
    blank                = BLANK_ZERO && !sync_q[PIPE_LAT-1].de;
    bus.post_frame_vsync = sync_q[PIPE_LAT-1].vsync;
    bus.post_frame_hsync = sync_q[PIPE_LAT-1].hsync;
    bus.post_frame_de    = sync_q[PIPE_LAT-1].de;
    bus.rgb888_r         = blank ? '0 : r_q;
    bus.rgb888_g         = blank ? '0 : g_q;
    bus.rgb888_b         = blank ? '0 : b_q;
  end

endmodule
